sliding_attack_engine: RTL
==========================

Name: sliding_attack_engine

Overview:
- Sequential, parametrised generator of sliding-piece attack and move sets for rook, bishop and queen on an N x N board.
- Walks one ray direction per clock, accumulating into a result register, then applies an own-piece mask and a popcount.
- Sits between the move-generation controller and the legal-move filter.
- Uses a valid/ready handshake on both input and output.

Parameters:
- N, 8, board side length; legal range 3..16.
- W, N*N, bitboard width (derived; do not override).
- CW, $clog2(N), coordinate width (derived).
- PW, $clog2(W+1), popcount width (derived).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  engine idle and able to accept a request
- in_occupied  in  W  all-piece occupancy; bit index = rank*N + file
- in_own  in  W  mover's own pieces
- in_file  in  CW  piece file
- in_rank  in  CW  piece rank
- in_kind  in  2  00 bishop, 01 rook, 10 queen, 11 reserved
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_attack  out  W  attacked squares, including the first blocker on each ray
- out_moves  out  W  out_attack & ~own
- out_count  out  PW  popcount(out_moves)
- out_err  out  1  coordinate out of range (file>=N or rank>=N)

Behaviour:
- Reset: one clock, asynchronous, active-high. All registers cleared. out_valid=0, out_attack=0, out_moves=0, out_count=0, out_err=0, state=IDLE.
- in_ready is a combinational decode of state==IDLE, so it reads 1 during and after reset.
- States:
  - IDLE: on in_valid&in_ready, capture occupied, own, file, rank and kind; clear the accumulator; go to SCAN, or to COUNT when kind=11 or the coordinate is out of range.
  - SCAN: process one direction per cycle.
  - COUNT: one cycle; register outputs; go to DONE.
  - DONE: out_valid=1 with outputs held stable; on out_ready go to IDLE. out_valid and all out_* clear on that same edge.
- Direction order, index 0..7: N, NE, E, SE, S, SW, W, NW.
  - Rook: 0, 2, 4, 6 (step 2).
  - Bishop: 1, 3, 5, 7 (step 2).
  - Queen: 0..7 (step 1).
  - The 3-bit direction counter starts at 1 for bishop and 0 otherwise. SCAN exits after the last enabled direction.
- Ray step (combinational, max N-1 squares):
  - Step from the piece square until the board edge.
  - Set each visited bit in the accumulator.
  - Stop after the first square whose occupied bit is 1.
  - The piece's own square bit in occupied is ignored. Rays never wrap across files.
- Latency from the accepting edge to out_valid high:
  - rook/bishop: 5 cycles
  - queen: 9 cycles
  - reserved kind or out-of-range coordinate: 1 cycle
- Reserved kind: zero result, out_err=0.
- Out-of-range coordinate: zero result, out_err=1.
- in_ready is 0 outside IDLE. Requests are not overlapped, and no accept happens in the same cycle as the out handshake. Input changes after acceptance are ignored.
- Reset asserted mid-SCAN or mid-DONE: the request is dropped with no output, and outputs return to 0 immediately.
- out_count range: 0..4*(N-1)+... bounded by W. PW covers W.

Decomposition:
- Shared package (chess_pkg):
  - kind encodings KIND_BISHOP, KIND_ROOK, KIND_QUEEN
  - direction indices DIR_N..DIR_NW with file/rank delta tables
  - state encoding
  - popcount function
- One natural sub-module: ray_walk, the combinational single-direction walker taking (occupied, file, rank, dir) and producing a W-bit ray mask, parametrised by N.

Test Plan:
- N=8, rook a1 (file0, rank0), occupied=1<<0, own=0 -> out_attack=out_moves=0x01010101010101FE, count=14, out_valid 5 cycles after accept.
- N=8, bishop d4 (3,3), occupied=1<<27 -> out_attack=0x8041221400142241, count=13, latency 5.
- N=8, queen d4, enemy at f4 (bit 29) and own at d6 (bit 43) -> out_attack includes bits 29 and 43, excludes 30, 31, 51 and 59; popcount(out_attack)=23; out_moves excludes 43; count=22; latency 9.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0; raise out_ready -> next cycle in_ready=1, out_valid=0.
- Assert rst during the 3rd SCAN cycle of a queen request -> all outputs 0 at once, in_ready=1; no out_valid after release; a new rook a1 request returns the correct result.
- N=6: kind=11 -> zero result, count 0, out_err=0, latency 1. Then file=6 -> zero result, out_err=1, latency 1.

Source files
------------

// File: rtl/chess_pkg.sv
`default_nettype none
// ============================================================================
// Module   : chess_pkg
// Purpose  : Shared definitions for the sliding-piece attack engine:
//            piece-kind encodings, ray direction indices with file/rank
//            delta lookups, FSM state encoding and a popcount helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package chess_pkg;

  // Piece kind encodings on in_kind
  localparam logic [1:0] KIND_BISHOP = 2'b00;
  localparam logic [1:0] KIND_ROOK   = 2'b01;
  localparam logic [1:0] KIND_QUEEN  = 2'b10;
  localparam logic [1:0] KIND_RSVD   = 2'b11;

  // Ray directions, walked in this numeric order
  localparam logic [2:0] DIR_N  = 3'd0;
  localparam logic [2:0] DIR_NE = 3'd1;
  localparam logic [2:0] DIR_E  = 3'd2;
  localparam logic [2:0] DIR_SE = 3'd3;
  localparam logic [2:0] DIR_S  = 3'd4;
  localparam logic [2:0] DIR_SW = 3'd5;
  localparam logic [2:0] DIR_W  = 3'd6;
  localparam logic [2:0] DIR_NW = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // File delta per direction (east is +1)
  function automatic int dir_df(input logic [2:0] dir);
    case (dir)
      DIR_NE, DIR_E, DIR_SE: dir_df = 1;
      DIR_SW, DIR_W, DIR_NW: dir_df = -1;
      default:               dir_df = 0;
    endcase
  endfunction

  // Rank delta per direction (north is +1)
  function automatic int dir_dr(input logic [2:0] dir);
    case (dir)
      DIR_NW, DIR_N, DIR_NE: dir_dr = 1;
      DIR_SE, DIR_S, DIR_SW: dir_dr = -1;
      default:               dir_dr = 0;
    endcase
  endfunction

  // Sized for the largest board (16x16); callers zero-extend and truncate.
  function automatic logic [8:0] popcount(input logic [255:0] v);
    logic [8:0] c;
    c = '0;
    for (int i = 0; i < 256; i++) begin
      c = c + {8'd0, v[i]};
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sliding_attack_engine_ray_walk.sv
`default_nettype none
// ============================================================================
// Module   : ray_walk
// Purpose  : Combinational single-direction ray walker. Steps outward from
//            the piece square until the board edge, marking every visited
//            square and stopping after the first occupied one.
// Ports    : occupied_i - occupancy bitboard (bit = rank*N + file)
//            file_i     - piece file
//            rank_i     - piece rank
//            dir_i      - direction index (N, NE, E, SE, S, SW, W, NW)
//            ray_o      - mask of squares reached along the ray
// Revision : 1.0 - initial release
// ============================================================================
module ray_walk
  import chess_pkg::*;
#(
  parameter  int N  = 8,
  localparam int W  = N * N,
  localparam int CW = $clog2(N),
  localparam int IW = $clog2(W)
) (
  input  logic [W-1:0]  occupied_i,
  input  logic [CW-1:0] file_i,
  input  logic [CW-1:0] rank_i,
  input  logic [2:0]    dir_i,
  output logic [W-1:0]  ray_o
);

  always_comb begin
    int         f;
    int         r;
    int         df;
    int         dr;
    logic       blocked;
    logic [IW-1:0] idx;
    ray_o   = '0;
    blocked = 1'b0;
    idx     = '0;
    df      = dir_df(dir_i);
    dr      = dir_dr(dir_i);
    f       = int'(file_i);
    r       = int'(rank_i);
    // Starting at the first neighbour means the piece's own occupancy bit
    // is never consulted. Once off-board a ray stays off-board, so the
    // bounds test also prevents wrapping across files.
    for (int k = 1; k < N; k++) begin
      f = f + df;
      r = r + dr;
      if (!blocked && f >= 0 && f < N && r >= 0 && r < N) begin
        idx        = IW'(r * N + f);
        ray_o[idx] = 1'b1;
        if (occupied_i[idx]) begin
          blocked = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sliding_attack_engine.sv
`default_nettype none
// ============================================================================
// Module   : sliding_attack_engine
// Purpose  : Sequential rook/bishop/queen attack-set generator. Walks one ray
//            direction per clock into an accumulator, then masks own pieces
//            and popcounts the resulting move set.
// Ports    : clk, rst                 - clock, async active-high reset
//            in_valid/in_ready        - request handshake
//            in_occupied, in_own      - occupancy / mover bitboards
//            in_file, in_rank, in_kind- piece square and kind
//            out_valid/out_ready      - result handshake
//            out_attack, out_moves    - attack set, attack & ~own
//            out_count, out_err       - popcount(out_moves), bad coordinate
// Revision : 1.0 - initial release
// ============================================================================
module sliding_attack_engine
  import chess_pkg::*;
#(
  parameter  int N  = 8,
  localparam int W  = N * N,
  localparam int CW = $clog2(N),
  localparam int PW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_occupied,
  input  logic [W-1:0]  in_own,
  input  logic [CW-1:0] in_file,
  input  logic [CW-1:0] in_rank,
  input  logic [1:0]    in_kind,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_attack,
  output logic [W-1:0]  out_moves,
  output logic [PW-1:0] out_count,
  output logic          out_err
);

  state_t        state_q, state_d;
  logic [W-1:0]  occ_q, occ_d;
  logic [W-1:0]  own_q, own_d;
  logic [CW-1:0] file_q, file_d;
  logic [CW-1:0] rank_q, rank_d;
  logic [1:0]    kind_q, kind_d;
  logic [2:0]    dir_q, dir_d;
  logic          err_q, err_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  attack_q, attack_d;
  logic [W-1:0]  moves_q, moves_d;
  logic [PW-1:0] count_q, count_d;
  logic          out_err_q, out_err_d;

  logic [W-1:0]  ray;
  logic [W-1:0]  masked;
  logic          bad_coord;
  logic          last_dir;

  ray_walk #(.N(N)) u_ray_walk (
    .occupied_i (occ_q),
    .file_i     (file_q),
    .rank_i     (rank_q),
    .dir_i      (dir_q),
    .ray_o      (ray)
  );

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign out_attack = attack_q;
  assign out_moves  = moves_q;
  assign out_count  = count_q;
  assign out_err    = out_err_q;

  assign masked    = acc_q & ~own_q;
  assign bad_coord = (int'(in_file) >= N) || (int'(in_rank) >= N);
  // Rook visits the even directions and ends on W; bishop and queen end on NW.
  assign last_dir  = (kind_q == KIND_ROOK) ? (dir_q == DIR_W) : (dir_q == DIR_NW);

  always_comb begin
    state_d   = state_q;
    occ_d     = occ_q;
    own_d     = own_q;
    file_d    = file_q;
    rank_d    = rank_q;
    kind_d    = kind_q;
    dir_d     = dir_q;
    err_d     = err_q;
    acc_d     = acc_q;
    attack_d  = attack_q;
    moves_d   = moves_q;
    count_d   = count_q;
    out_err_d = out_err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          occ_d  = in_occupied;
          own_d  = in_own;
          file_d = in_file;
          rank_d = in_rank;
          kind_d = in_kind;
          acc_d  = '0;
          err_d  = bad_coord;
          dir_d  = (in_kind == KIND_BISHOP) ? DIR_NE : DIR_N;
          // Invalid requests skip the walk; the cleared accumulator yields a zero result.
          state_d = (bad_coord || in_kind == KIND_RSVD) ? ST_COUNT : ST_SCAN;
        end
      end
      ST_SCAN: begin
        acc_d = acc_q | ray;
        dir_d = dir_q + ((kind_q == KIND_QUEEN) ? 3'd1 : 3'd2);
        if (last_dir) begin
          state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        attack_d  = acc_q;
        moves_d   = masked;
        count_d   = PW'(popcount(256'(masked)));
        out_err_d = err_q;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          attack_d  = '0;
          moves_d   = '0;
          count_d   = '0;
          out_err_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      occ_q     <= '0;
      own_q     <= '0;
      file_q    <= '0;
      rank_q    <= '0;
      kind_q    <= '0;
      dir_q     <= '0;
      err_q     <= 1'b0;
      acc_q     <= '0;
      attack_q  <= '0;
      moves_q   <= '0;
      count_q   <= '0;
      out_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      occ_q     <= occ_d;
      own_q     <= own_d;
      file_q    <= file_d;
      rank_q    <= rank_d;
      kind_q    <= kind_d;
      dir_q     <= dir_d;
      err_q     <= err_d;
      acc_q     <= acc_d;
      attack_q  <= attack_d;
      moves_q   <= moves_d;
      count_q   <= count_d;
      out_err_q <= out_err_d;
    end
  end

endmodule
`default_nettype wire
